// File: rtl/modport_dff.sv
// Set/clear D register with complementary outputs, change pulse and saturating
// set/clear event counters; storage element behind the MP1 modport bundle.
module modport_dff #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             s,
  input  logic             r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_b,
  output logic             q_changed,
  output logic [CNT_W-1:0] set_cnt,
  output logic [CNT_W-1:0] clr_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       rst_sync;
  logic             run;
  logic [WIDTH-1:0] q_next;
  logic             set_inc;
  logic             clr_inc;

  // Release chain: state is frozen at its reset value until the chain starts
  // filling, so the second rising edge after rst_n rises is the first honoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run = |rst_sync;

  // Clear beats set, set beats data.
  always_comb begin
    q_next = q;
    if (r) begin
      q_next = '0;
    end else if (s) begin
      q_next = '1;
    end else begin
      q_next = d;
    end
  end

  assign set_inc = run & s & ~r;
  assign clr_inc = run & r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q         <= '0;
      q_b       <= '1;
      q_changed <= 1'b0;
    end else if (run) begin
      q         <= q_next;
      q_b       <= ~q_next;
      q_changed <= (q_next != q);
    end else begin
      q_changed <= 1'b0;
    end
  end

  // Counters stick at all ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_cnt <= '0;
      clr_cnt <= '0;
    end else begin
      if (set_inc && (set_cnt != CNT_MAX)) begin
        set_cnt <= set_cnt + 1'b1;
      end
      if (clr_inc && (clr_cnt != CNT_MAX)) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_modport_dff.sv
// Scoreboard bench for modport_dff: a behavioural model pushes expected
// outputs per driven edge; they are popped and compared one edge later.
module tb_modport_dff;

  localparam int W     = 4;
  localparam int CW    = 3;
  localparam int C_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  d;
  logic          s;
  logic          r;
  logic [W-1:0]  q;
  logic [W-1:0]  q_b;
  logic          q_changed;
  logic [CW-1:0] set_cnt;
  logic [CW-1:0] clr_cnt;

  typedef struct {
    string        tag;
    logic [W-1:0] q;
    logic [W-1:0] q_b;
    logic         qc;
    int           set_c;
    int           clr_c;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_q;
  int           m_set;
  int           m_clr;
  int           rel_edges;

  modport_dff #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .s(s), .r(r),
    .q(q), .q_b(q_b), .q_changed(q_changed),
    .set_cnt(set_cnt), .clr_cnt(clr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".q"}, 32'(q), 32'(0));
    checkOutput({tag, ".q_b"}, 32'(q_b), 32'({W{1'b1}}));
    checkOutput({tag, ".qc"}, 32'(q_changed), 32'(0));
    checkOutput({tag, ".set"}, 32'(set_cnt), 32'(0));
    checkOutput({tag, ".clr"}, 32'(clr_cnt), 32'(0));
  endtask

  task automatic modelReset();
    m_q = '0;
    m_set = 0;
    m_clr = 0;
    rel_edges = 0;
  endtask

  // Drives one edge's worth of inputs now, models that edge, checks after it.
  task automatic applyStimulus(input logic s_i, input logic r_i, input logic [W-1:0] d_i, input string tag);
    exp_t         e;
    exp_t         got;
    logic [W-1:0] nq;
    s = s_i;
    r = r_i;
    d = d_i;
    e.qc = 1'b0;
    if (rel_edges >= 1) begin
      if (r_i) nq = '0;
      else if (s_i) nq = '1;
      else nq = d_i;
      e.qc = (nq != m_q);
      m_q = nq;
      if (r_i) m_clr = (m_clr == C_MAX) ? C_MAX : m_clr + 1;
      else if (s_i) m_set = (m_set == C_MAX) ? C_MAX : m_set + 1;
    end
    rel_edges++;
    e.tag = tag;
    e.q = m_q;
    e.q_b = ~m_q;
    e.set_c = m_set;
    e.clr_c = m_clr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    checkOutput({got.tag, ".q"}, 32'(q), 32'(got.q));
    checkOutput({got.tag, ".q_b"}, 32'(q_b), 32'(got.q_b));
    checkOutput({got.tag, ".qc"}, 32'(q_changed), 32'(got.qc));
    checkOutput({got.tag, ".set"}, 32'(set_cnt), 32'(got.set_c));
    checkOutput({got.tag, ".clr"}, 32'(clr_cnt), 32'(got.clr_c));
  endtask

  initial begin
    rst_n = 1'b1;
    s = 1'b1;
    r = 1'b0;
    d = '1;
    modelReset();
    #1 rst_n = 1'b0;
    #1 checkReset("rst_async");
    @(posedge clk);
    #1 checkReset("rst_held");
    #2 rst_n = 1'b1;

    applyStimulus(1'b0, 1'b0, 4'hF, "release_edge1");
    applyStimulus(1'b0, 1'b0, 4'hF, "d_ones");
    applyStimulus(1'b0, 1'b0, 4'hF, "d_hold");
    applyStimulus(1'b0, 1'b0, 4'h5, "d_5");
    applyStimulus(1'b0, 1'b0, 4'hA, "d_a");
    applyStimulus(1'b0, 1'b0, 4'h0, "d_0");

    applyStimulus(1'b1, 1'b0, 4'h3, "set1");
    applyStimulus(1'b1, 1'b0, 4'h3, "set2");
    applyStimulus(1'b0, 1'b1, 4'h3, "clr1");
    applyStimulus(1'b0, 1'b0, 4'h0, "after_clr");

    applyStimulus(1'b0, 1'b0, 4'h6, "pre_both");
    applyStimulus(1'b1, 1'b1, 4'h6, "both");

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 4'h0, $sformatf("to5_%0d", i));

    // Asynchronous reset pulse between edges, then the delayed release.
    #1 rst_n = 1'b0;
    #1 checkReset("rst_mid");
    #1 rst_n = 1'b1;
    modelReset();
    applyStimulus(1'b1, 1'b0, 4'h0, "mid_edge1");
    applyStimulus(1'b1, 1'b0, 4'h0, "mid_edge2");

    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 4'h0, $sformatf("sat_set_%0d", i));
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 4'hF, $sformatf("sat_clr_%0d", i));

    for (int i = 0; i < 30; i++) begin
      applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                    W'($urandom), $sformatf("rand_%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
